// File: rtl/multicycle_adder_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_adder_subtractor: LSB-first chunked add/sub, CHUNK bits/cycle,  |
// | start/busy/done handshake. Optional ovf/zero flags under ADDSUB_FLAGS_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             M,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Te,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Ts,
  output logic             ovf,
  output logic             zero
);

  localparam int c_NUM_CHUNKS = WIDTH / CHUNK;
  localparam int c_CNT_W      = (c_NUM_CHUNKS > 1) ? $clog2(c_NUM_CHUNKS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NUM_CHUNKS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("multicycle_adder_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_m;
  logic                 r_t;
  logic [WIDTH-1:0]     r_s;
  logic                 r_ts;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_last;
  logic [CHUNK-1:0]     w_a_chunk;
  logic [CHUNK-1:0]     w_b_chunk;
  logic [CHUNK-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_s_next;
`ifdef ADDSUB_FLAGS_EN
  logic                 w_cin_msb;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pick out the operand bits belonging to the chunk currently being processed.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (c_CNT_W'(i / CHUNK) == r_cnt) begin
        w_a_chunk[i % CHUNK] = r_a[i];
        w_b_chunk[i % CHUNK] = r_b[i];
      end
    end
  end

  always_comb begin
    logic v_t;
    v_t   = r_t;
    w_sum = '0;
`ifdef ADDSUB_FLAGS_EN
    w_cin_msb = 1'b0;
`endif
    for (int j = 0; j < CHUNK; j++) begin
`ifdef ADDSUB_FLAGS_EN
      if (j == CHUNK - 1) w_cin_msb = v_t;
`endif
      w_sum[j] = w_a_chunk[j] ^ w_b_chunk[j] ^ v_t;
      if (r_m) v_t = (~w_a_chunk[j] & w_b_chunk[j]) | (~w_a_chunk[j] & v_t) | (w_b_chunk[j] & v_t);
      else     v_t = (w_a_chunk[j] & w_b_chunk[j]) | (w_a_chunk[j] & v_t) | (w_b_chunk[j] & v_t);
    end
    w_cout = v_t;
  end

  always_comb begin
    w_s_next = r_s;
    for (int i = 0; i < WIDTH; i++) begin
      if (c_CNT_W'(i / CHUNK) == r_cnt) w_s_next[i] = w_sum[i % CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= 1'b0;
      r_t    <= 1'b0;
      r_s    <= '0;
      r_ts   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= A;
        r_b   <= B;
        r_m   <= M;
        r_t   <= Te;
        r_cnt <= '0;
        r_s   <= '0;
        r_ts  <= 1'b0;
      end else if (r_state == RUN) begin
        r_s   <= w_s_next;
        r_t   <= w_cout;
        r_cnt <= r_cnt + c_CNT_W'(1);
        if (w_last) begin
          r_ts   <= w_cout;
          r_done <= 1'b1;
        end
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // Overflow is carry/borrow into the MSB XOR out of it, valid for both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_ovf  <= w_cin_msb ^ w_cout;
      r_zero <= (w_s_next == '0);
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign S    = r_s;
  assign Ts   = r_ts;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_adder_subtractor: directed self-checking bench, 8-bit DUTs   |
// | with CHUNK=1 and CHUNK=4.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_adder_subtractor;

`ifdef ADDSUB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic       M = 1'b0;
  logic       Te = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       busy1, done1, Ts1, ovf1, zero1;
  logic       busy4, done4, Ts4, ovf4, zero4;
  logic [7:0] S1, S4;

  int checks = 0;
  int errors = 0;

  multicycle_adder_subtractor #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .M(M), .A(A), .B(B), .Te(Te),
    .busy(busy1), .done(done1), .S(S1), .Ts(Ts1), .ovf(ovf1), .zero(zero1)
  );

  multicycle_adder_subtractor #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .M(M), .A(A), .B(B), .Te(Te),
    .busy(busy4), .done(done4), .S(S4), .Ts(Ts4), .ovf(ovf4), .zero(zero4)
  );

  always #5 clk = ~clk;

  // Vector table: M, A, B, Te -> S, Ts, ovf, zero (ovf/zero before flag gating)
  logic       v_m   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] v_a   [4] = '{8'h5A, 8'h10, 8'hFF, 8'h80};
  logic [7:0] v_b   [4] = '{8'h3C, 8'h20, 8'h00, 8'h01};
  logic       v_te  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] v_s   [4] = '{8'h96, 8'hF0, 8'h00, 8'h7F};
  logic       v_ts  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       v_ovf [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       v_zero[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic drive(input bit wide, input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic te);
    @(negedge clk);
    M = m; A = a; B = b; Te = te;
    if (wide) start4 = 1'b1;
    else      start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
    A = 8'hA5; B = 8'h5A; M = ~m; Te = ~te;
  endtask

  task automatic wait_done(input bit wide, output int cyc, output int bcyc);
    cyc = 0;
    bcyc = 0;
    while (((wide ? done4 : done1) !== 1'b1) && (cyc < 20)) begin
      if ((wide ? busy4 : busy1) === 1'b1) bcyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int ndone;
    #1;
    checks++;
    if ({busy1, done1, S1, Ts1, ovf1, zero1} !== 13'b0) begin
      errors++;
      $display("FAIL reset_c1: got busy=%b done=%b S=%h Ts=%b ovf=%b zero=%b expected all 0",
               busy1, done1, S1, Ts1, ovf1, zero1);
    end
    checks++;
    if ({busy4, done4, S4, Ts4, ovf4, zero4} !== 13'b0) begin
      errors++;
      $display("FAIL reset_c4: got busy=%b done=%b S=%h Ts=%b ovf=%b zero=%b expected all 0",
               busy4, done4, S4, Ts4, ovf4, zero4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d busy/done cycles expected 0", ndone);
    end
  endtask

  task automatic test_arith();
    int cyc, bcyc;
    logic [7:0] held;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, v_m[k], v_a[k], v_b[k], v_te[k]);
      wait_done(1'b0, cyc, bcyc);
      checks++;
      if (cyc !== 8 || bcyc !== 8) begin
        errors++;
        $display("FAIL arith%0d latency: got done after %0d busy %0d expected 8/8", k, cyc, bcyc);
      end
      checks++;
      if (S1 !== v_s[k] || Ts1 !== v_ts[k] || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL arith%0d result: got S=%h Ts=%b busy=%b expected S=%h Ts=%b busy=0",
                 k, S1, Ts1, busy1, v_s[k], v_ts[k]);
      end
      checks++;
      if (ovf1 !== (v_ovf[k] & FL) || zero1 !== (v_zero[k] & FL)) begin
        errors++;
        $display("FAIL arith%0d flags: got ovf=%b zero=%b expected ovf=%b zero=%b",
                 k, ovf1, zero1, v_ovf[k] & FL, v_zero[k] & FL);
      end
      held = S1;
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b0 || S1 !== v_s[k]) begin
        errors++;
        $display("FAIL arith%0d hold: got done=%b S=%h expected done=0 S=%h", k, done1, S1, held);
      end
    end
  endtask

  task automatic test_handshake();
    int cyc, bcyc;
    drive(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    start1 = 1'b1; M = 1'b1; A = 8'hFF; B = 8'hFF; Te = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL ignore_start latency: got %0d more cycles expected 5", cyc);
    end
    checks++;
    if (S1 !== 8'h46 || Ts1 !== 1'b0 || ovf1 !== 1'b0 || zero1 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result: got S=%h Ts=%b ovf=%b zero=%b expected S=46 Ts=0 ovf=0 zero=0",
               S1, Ts1, ovf1, zero1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start retrigger: got busy=%b done=%b expected 0/0", busy1, done1);
    end
  endtask

  task automatic test_abort();
    int cyc, bcyc, ndone;
    drive(1'b0, 1'b0, 8'h55, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy1 !== 1'b1 || S1 !== 8'h05) begin
      errors++;
      $display("FAIL abort_partial: got busy=%b S=%h expected busy=1 S=05", busy1, S1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, S1, Ts1, ovf1, zero1} !== 13'b0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b S=%h Ts=%b ovf=%b zero=%b expected all 0",
               busy1, done1, S1, Ts1, ovf1, zero1);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
    end
    drive(1'b0, 1'b1, 8'h07, 8'h09, 1'b1);
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 8 || S1 !== 8'hFD || Ts1 !== 1'b1 || ovf1 !== 1'b0 || zero1 !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: got cyc=%0d S=%h Ts=%b ovf=%b zero=%b expected cyc=8 S=FD Ts=1 ovf=0 zero=0",
               cyc, S1, Ts1, ovf1, zero1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    drive(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 8 || S1 !== 8'h80 || Ts1 !== 1'b0 || ovf1 !== FL) begin
      errors++;
      $display("FAIL b2b_first: got cyc=%0d S=%h Ts=%b ovf=%b expected cyc=8 S=80 Ts=0 ovf=%b",
               cyc, S1, Ts1, ovf1, FL);
    end
    drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checks++;
    if (busy1 !== 1'b1 || S1 !== 8'h00 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b S=%h ovf=%b expected busy=1 S=00 ovf=0", busy1, S1, ovf1);
    end
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 8 || S1 !== 8'h00 || Ts1 !== 1'b0 || ovf1 !== 1'b0 || zero1 !== FL) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d S=%h Ts=%b ovf=%b zero=%b expected cyc=8 S=00 Ts=0 ovf=0 zero=%b",
               cyc, S1, Ts1, ovf1, zero1, FL);
    end
  endtask

  task automatic test_wide_chunk();
    int cyc, bcyc;
    drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
    wait_done(1'b1, cyc, bcyc);
    checks++;
    if (cyc !== 2 || bcyc !== 2) begin
      errors++;
      $display("FAIL chunk4 latency: got %0d busy %0d expected 2/2", cyc, bcyc);
    end
    checks++;
    if (S4 !== 8'hFF || Ts4 !== 1'b1 || ovf4 !== 1'b0 || zero4 !== 1'b0) begin
      errors++;
      $display("FAIL chunk4 borrow: got S=%h Ts=%b ovf=%b zero=%b expected S=FF Ts=1 ovf=0 zero=0",
               S4, Ts4, ovf4, zero4);
    end
    drive(1'b1, 1'b0, 8'h5A, 8'h3C, 1'b0);
    wait_done(1'b1, cyc, bcyc);
    checks++;
    if (cyc !== 2 || S4 !== 8'h96 || Ts4 !== 1'b0 || ovf4 !== FL || zero4 !== 1'b0) begin
      errors++;
      $display("FAIL chunk4 add: got cyc=%0d S=%h Ts=%b ovf=%b zero=%b expected cyc=2 S=96 Ts=0 ovf=%b zero=0",
               cyc, S4, Ts4, ovf4, zero4, FL);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_handshake();
    test_abort();
    test_back_to_back();
    test_wide_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
